// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready add/subtract unit with the WIDTH-bit carry
// chain cut into STAGES segments of WIDTH/STAGES bits, one segment per stage.
//
// Stage k register layout (x_q/y_q are full-width words):
//   x_q[k] : finished sum slices in bits [0 +: (k+1)*C], raw A slices above
//   y_q[k] : mode-conditioned B (only slices above the boundary matter)
//   c_q[k] : carry out of segment k, consumed by stage k+1
//   v_q[k] : valid bit travelling with the data
// Every slice moves one stage per advance. Unprocessed operand slices are
// therefore skewed, and finished sum slices are delayed, so that the whole
// word leaves stage STAGES-1 in one piece. That last stage is the output
// register.
//
// Optional build: define PIPELINED_ADDSUB_OVF_EN to add the registered
// signed-overflow output 'ovf'.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic                         advance;
    logic [WIDTH-1:0]             b_cond;
    logic                         cin_cond;

    logic [STAGES-1:0]            v_q, v_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] x_q, x_d;
    logic [STAGES-1:0][WIDTH-1:0] y_q, y_d;

    // Stage inputs: index 0 is the port side, index k>0 is stage k-1's register.
    // The extra top entry is the output side of the last stage.
    logic [STAGES:0]              v_in, c_in;
    logic [STAGES:0][WIDTH-1:0]   x_in, y_in;

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic                         ovf_q, ovf_d;
`endif

    // Subtract is a + ~b + ~cin. The inversion is applied once at entry, so
    // the mode does not need to travel down the pipe.
    assign b_cond   = sub ? ~b : b;
    assign cin_cond = sub ? ~cin : cin;

    assign v_in = {v_q, in_valid};
    assign c_in = {c_q, cin_cond};
    assign x_in = {x_q, a};
    assign y_in = {y_q, b_cond};

    // The whole pipe moves unless a presented result is being refused.
    // There is no bubble collapsing, so in_ready does not look at in_valid.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    assign out_valid = v_in[STAGES];
    assign sum       = x_in[STAGES];
    assign cout      = c_in[STAGES];

    // Per-stage next state: add segment k with the carry from the previous
    // stage, and pass every other slice through unchanged.
    always_comb begin
        logic [C:0] t;
        t   = '0;
        v_d = '0;
        c_d = '0;
        x_d = '0;
        y_d = '0;
`ifdef PIPELINED_ADDSUB_OVF_EN
        ovf_d = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, x_in[k][k*C +: C]} + {1'b0, y_in[k][k*C +: C]}
              + {{C{1'b0}}, c_in[k]};
            v_d[k]             = v_in[k];
            c_d[k]             = t[C];
            x_d[k]             = x_in[k];
            x_d[k][k*C +: C]   = t[C-1:0];
            y_d[k]             = y_in[k];
        end
`ifdef PIPELINED_ADDSUB_OVF_EN
        // The carry into the MSB is recovered from the MSB's own sum bit:
        // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
        ovf_d = c_d[STAGES-1]
              ^ (x_in[STAGES-1][WIDTH-1] ^ y_in[STAGES-1][WIDTH-1]
                 ^ x_d[STAGES-1][WIDTH-1]);
`endif
    end

    // Stage registers. Reset clears everything and drops any in-flight
    // work. A stall freezes valid bits, carries and data together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            v_q <= v_d;
            c_q <= c_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

`ifdef PIPELINED_ADDSUB_OVF_EN
    // Overflow flag, registered alongside the final sum slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, STAGES=4). It covers a
// vector table with latency checks, full throughput, backpressure, and reset
// while transactions are in flight.
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic             cin, sub, cout;
    logic [WIDTH-1:0] a, b, sum;
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[13];

    int          sent, rcv, gaps, held, seen;
    bit          started, rdy_ok;
    logic [15:0] snap_s, exp_s;
    logic        snap_c;
    logic [15:0] expq[$];

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one operand pair, then wait a bounded time for the result and check it.
    task automatic apply_vec(input string nm, input vec_t v);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, ".latency"}, 32'(lat), 32'(STAGES));
        check({nm, ".sum"}, 32'(sum), 32'(v.s));
        check({nm, ".cout"}, 32'(cout), 32'(v.co));
`ifdef PIPELINED_ADDSUB_OVF_EN
        check({nm, ".ovf"}, 32'(ovf), 32'(v.ov));
`endif
    endtask

    initial begin
        //            a         b         cin   sub   sum       cout  ovf
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 1'b1, 16'h9998, 1'b1, 1'b0};
        vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[12] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDSUB_OVF_EN
        check("reset.ovf", 32'(ovf), 32'd0);
`endif

        // Single transactions from the table.
        for (int i = 0; i < 13; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (STAGES + 1) tick();

        // Full throughput: a=i, b=2i for 20 back-to-back inputs.
        sent = 0; rcv = 0; gaps = 0; started = 1'b0; rdy_ok = 1'b1;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 20; cyc++) begin
            in_valid = (sent < 20);
            a = 16'(sent); b = 16'(2 * sent);
            #1;
            if (out_valid) begin
                check("thru.sum", 32'(sum), 32'(16'(3 * rcv)));
                rcv++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            if (in_valid && !in_ready) rdy_ok = 1'b0;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        check("thru.count", 32'(rcv), 32'd20);
        check("thru.gaps", 32'(gaps), 32'd0);
        check("thru.in_ready", 32'(rdy_ok), 32'd1);
        repeat (STAGES + 1) tick();

        // Backpressure: fill with out_ready low, hold for 5 cycles, then drain.
        sent = 0; rcv = 0; held = 0;
        expq.delete();
        snap_s = '0; snap_c = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            in_valid = (sent < 8);
            a = 16'h0100 + 16'(sent); b = 16'(3 * sent); cin = 1'b0; sub = 1'b0;
            out_ready = (held >= 5);
            #1;
            if (held > 0 && held < 5) begin
                check("bp.out_valid_held", 32'(out_valid), 32'd1);
                check("bp.sum_held", 32'(sum), 32'(snap_s));
                check("bp.cout_held", 32'(cout), 32'(snap_c));
                check("bp.in_ready_low", 32'(in_ready), 32'd0);
                held++;
            end else if (held == 0 && out_valid) begin
                snap_s = sum; snap_c = cout;
                check("bp.in_ready_low", 32'(in_ready), 32'd0);
                held = 1;
            end
            if (in_valid && in_ready) begin
                expq.push_back(16'h0100 + 16'(4 * sent));
                sent++;
            end
            if (out_valid && out_ready) begin
                exp_s = (expq.size() > 0) ? expq.pop_front() : 16'hDEAD;
                check("bp.sum_order", 32'(sum), 32'(exp_s));
                rcv++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp.received", 32'(rcv), 32'd8);
        check("bp.leftover", 32'(expq.size()), 32'd0);
        check("bp.stall_cycles", 32'(held), 32'd5);
        repeat (STAGES + 1) tick();

        // Reset with 3 transactions in flight, plus an input offered during reset.
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'(16'h1111 * (i + 1)); b = 16'h0001;
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sum", 32'(sum), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst.ghost_results", 32'(seen), 32'd0);
        apply_vec("rst.new", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
